reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

Round-robin write arbiter that shares a single WIDTH-bit D-flip-flop storage register between four requesters. Each cycle it selects at most one pending requester, loads that requester's data into the shared register on the clock edge, and returns a one-cycle acknowledge. It sits in front of the shared register, is its only writer, and exposes the stored value plus ownership and write-count status to downstream logic.

## Interface
- WIDTH, 8, data width of each requester's input and of the shared register
- CNTW, 8, width of the write counter

- clk  input  1  single clock; all state updates on posedge clk
- rst  input  1  synchronous, active-high reset, sampled on posedge clk
- req  input  4  req[i] high: requester i requests a write
- din  input  4*WIDTH  requester i data on din[i*WIDTH +: WIDTH]
- ack  output  4  one-hot, one-cycle pulse; ack[i] high: requester i's data was written on the preceding edge
- q  output  WIDTH  shared register contents
- owner  output  2  index of the last requester written
- valid  output  1  sticky; high once any write has occurred since reset
- wr_count  output  CNTW  number of writes since reset, wraps modulo 2^CNTW

## Operation
- State: q, owner, valid, wr_count, ack, 2-bit round-robin pointer ptr, and a 2-state FSM {IDLE, ACK}.
- Effective request: eff[i] = req[i] & ~ack[i]. A requester whose ack is currently high is masked for that cycle, so holding req through ack cannot produce a back-to-back double write.
- Arbitration: scan eff starting at index ptr, upward modulo 4; the first set bit wins. ptr = 0 gives priority 0,1,2,3.
- On an edge with a winner w:
  - q <= din[w]
  - owner <= w
  - ack <= one-hot(w)
  - valid <= 1
  - wr_count <= wr_count + 1, wrapping
  - ptr <= (w + 1) mod 4
  - FSM -> ACK
- On an edge with no winner:
  - ack <= 0
  - q, owner, valid, wr_count and ptr hold
  - FSM -> IDLE
- FSM: IDLE -> ACK on a winner. ACK -> ACK on a winner, which allows back-to-back writes from different requesters. ACK -> IDLE with no winner. ack is nonzero exactly when FSM = ACK.
- Requester protocol: keep req and din stable until ack[i] is seen, then drop req in that ack cycle. If req is still high in the cycle after ack, that is a new request.
- A requester may drop req before being acked. Nothing is written for it, and no error is flagged.
- Only the winner is acked. Losers remain pending, and their data is not sampled.

## Timing
- Latency: req[i] sampled at edge t; q and ack[i] change at edge t, visible through cycle t+1. Request-to-ack is 1 cycle when uncontended.
- Throughput: one write per cycle when two or more requesters are pending. A single requester achieves at most one write per 2 cycles because of masking.
- Worst-case wait under full contention is 3 write cycles.
- Reset, sampled on any edge with rst = 1, overrides all other activity in that cycle, including an in-progress grant. State after that edge:
  - q = 0
  - owner = 0
  - valid = 0
  - wr_count = 0
  - ack = 0
  - ptr = 0
  - FSM = IDLE
- No output is combinational from inputs; all outputs are registered.
- wr_count wraps from 2^CNTW−1 to 0 with no flag, and valid stays 1.

## Test plan
- Reset: drive random req/din with rst = 1 for 2 cycles -> q = 0, ack = 0, owner = 0, valid = 0, wr_count = 0. First request after reset with req = 4'b1111 -> requester 0 wins.
- Single requester: req = 4'b0100, din[2] = 8'hA5, held for 4 cycles.
  - After the first edge: q = A5, ack = 4'b0100, owner = 2.
  - Next cycle: ack = 0.
  - The pattern then repeats: 2 writes in 4 cycles, wr_count = 2.
- Full contention: req = 4'b1111 held, din[i] = 8'h10+i.
  - ack sequence is 0001, 0010, 0100, 1000, 0001, …
  - q follows 10, 11, 12, 13, 10.
  - ack is never zero between writes.
- Round-robin fairness: after requester 3 wins, assert req = 4'b1001 -> requester 0 wins next. After requester 0 wins, assert req = 4'b1001 -> requester 3 wins next.
- Mid-operation reset: req = 4'b0011, assert rst on the edge where requester 1 would win -> no ack, q = 0, ptr = 0. Release rst -> requester 0 wins first.
- Counter wrap: with CNTW = 4, perform 17 writes -> wr_count = 1, valid = 1.

Source files
------------

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter
// Purpose  : Round-robin write arbiter in front of a single shared WIDTH-bit
//            storage register with four requesters. Each cycle at most one
//            pending requester is selected. Its data is loaded into the shared
//            register on the clock edge, and it receives a one-cycle
//            acknowledge. The arbiter is the only writer of the register.
//
// Ports    : clk       - single clock, all state updates on posedge
//            rst       - synchronous active-high reset
//            req[3:0]  - req[i] high: requester i requests a write
//            din       - requester i data on din[i*WIDTH +: WIDTH]
//            ack[3:0]  - one-hot, one-cycle pulse for the requester written
//                        on the preceding edge
//            q         - shared register contents
//            owner     - index of the last requester written
//            valid     - sticky, high once any write has occurred
//            wr_count  - number of writes since reset, wraps modulo 2^CNTW
//
// Revision : 1.0 - initial release
// ============================================================================
module reg_write_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   din,
    output logic [3:0]           ack,
    output logic [WIDTH-1:0]     q,
    output logic [1:0]           owner,
    output logic                 valid,
    output logic [CNTW-1:0]      wr_count
);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_ACK  = 1'b1;

    logic [0:0]        r_state;
    logic [3:0]        r_ack;
    logic [WIDTH-1:0]  r_q;
    logic [1:0]        r_owner;
    logic              r_valid;
    logic [CNTW-1:0]   r_wr_count;
    logic [1:0]        r_ptr;

    logic [3:0]        w_eff;
    logic              w_hit;
    logic [1:0]        w_win;
    logic [WIDTH-1:0]  w_win_data;

    // A requester whose ack is showing this cycle is masked, so a req held
    // through its own ack cycle cannot be written twice back-to-back.
    assign w_eff = req & ~r_ack;

    // Scan upward from the round-robin pointer. The 2-bit sum wraps
    // naturally modulo 4; the first set bit wins.
    always_comb begin
        logic [1:0] v_idx;
        w_hit = 1'b0;
        w_win = 2'd0;
        v_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            v_idx = r_ptr + 2'(k);
            if (!w_hit && w_eff[v_idx]) begin
                w_hit = 1'b1;
                w_win = v_idx;
            end
        end
    end

    assign w_win_data = din[w_win*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_ack      <= 4'd0;
            r_q        <= '0;
            r_owner    <= 2'd0;
            r_valid    <= 1'b0;
            r_wr_count <= '0;
            r_ptr      <= 2'd0;
        end else begin
            case (r_state)
                c_ST_IDLE,
                c_ST_ACK: begin
                    if (w_hit) begin
                        // Back-to-back grants from different requesters are
                        // allowed, so ACK can be re-entered directly.
                        r_state    <= c_ST_ACK;
                        r_ack      <= 4'b0001 << w_win;
                        r_q        <= w_win_data;
                        r_owner    <= w_win;
                        r_valid    <= 1'b1;
                        r_wr_count <= r_wr_count + 1'b1;
                        r_ptr      <= w_win + 2'd1;
                    end else begin
                        r_state    <= c_ST_IDLE;
                        r_ack      <= 4'd0;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_ack   <= 4'd0;
                end
            endcase
        end
    end

    assign ack      = r_ack;
    assign q        = r_q;
    assign owner    = r_owner;
    assign valid    = r_valid;
    assign wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_write_arbiter
// Purpose  : Self-checking bench for reg_write_arbiter. Each driven cycle
//            steps a behavioural model of the arbitration rules and queues
//            the expected post-edge outputs. An independent monitor pops one
//            entry after every edge and compares it with the DUT outputs.
//            Directed checks for the listed scenarios are added on top.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

    localparam int c_WIDTH = 8;
    localparam int c_CNTW  = 4;

    logic                  clk;
    logic                  rst;
    logic [3:0]            req;
    logic [4*c_WIDTH-1:0]  din;
    logic [3:0]            ack;
    logic [c_WIDTH-1:0]    q;
    logic [1:0]            owner;
    logic                  valid;
    logic [c_CNTW-1:0]     wr_count;

    reg_write_arbiter #(.WIDTH(c_WIDTH), .CNTW(c_CNTW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .din      (din),
        .ack      (ack),
        .q        (q),
        .owner    (owner),
        .valid    (valid),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]         ack;
        logic [c_WIDTH-1:0] q;
        logic [1:0]         owner;
        logic               valid;
        logic [c_CNTW-1:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference state, kept as plain integers.
    int m_q     = 0;
    int m_owner = 0;
    int m_valid = 0;
    int m_cnt   = 0;
    int m_ack   = 0;
    int m_ptr   = 0;

    // Apply one cycle of stimulus, step the model, queue its prediction,
    // then wait until just after the edge.
    task automatic drive(input logic r, input logic [3:0] rq, input logic [4*c_WIDTH-1:0] d);
        int   eff;
        int   w;
        exp_t e;
        @(negedge clk);
        rst = r;
        req = rq;
        din = d;
        if (r) begin
            m_q = 0; m_owner = 0; m_valid = 0; m_cnt = 0; m_ack = 0; m_ptr = 0;
        end else begin
            eff = int'(rq) & ~m_ack;
            w = -1;
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && eff[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            end
            if (w >= 0) begin
                m_q     = int'(d[w*c_WIDTH +: c_WIDTH]);
                m_owner = w;
                m_ack   = 1 << w;
                m_valid = 1;
                m_cnt   = (m_cnt + 1) % (1 << c_CNTW);
                m_ptr   = (w + 1) % 4;
            end else begin
                m_ack = 0;
            end
        end
        e.ack   = 4'(m_ack);
        e.q     = c_WIDTH'(m_q);
        e.owner = 2'(m_owner);
        e.valid = (m_valid != 0);
        e.cnt   = c_CNTW'(m_cnt);
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: one prediction per edge, compared just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (ack !== e.ack || q !== e.q || owner !== e.owner ||
                valid !== e.valid || wr_count !== e.cnt) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t: got ack=%b q=%h owner=%0d valid=%b cnt=%0d, expected ack=%b q=%h owner=%0d valid=%b cnt=%0d",
                         $time, ack, q, owner, valid, wr_count,
                         e.ack, e.q, e.owner, e.valid, e.cnt);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [4*c_WIDTH-1:0] contention_data();
        return {8'h13, 8'h12, 8'h11, 8'h10};
    endfunction

    initial begin
        int wait_cyc;
        rst = 1'b1;
        req = 4'd0;
        din = '0;

        // Reset with random activity on the inputs.
        drive(1'b1, 4'($urandom_range(0, 15)), $urandom);
        drive(1'b1, 4'($urandom_range(0, 15)), $urandom);
        check("reset_q",     32'(q), 32'h0);
        check("reset_ack",   32'(ack), 32'h0);
        check("reset_owner", 32'(owner), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_cnt",   32'(wr_count), 32'h0);
        drive(1'b0, 4'b1111, $urandom);
        check("first_after_reset_ack", 32'(ack), 32'h1);

        // Single requester held: writes every other cycle.
        drive(1'b1, 4'b0000, '0);
        drive(1'b0, 4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00});
        check("single_q",     32'(q), 32'hA5);
        check("single_ack",   32'(ack), 32'h4);
        check("single_owner", 32'(owner), 32'h2);
        drive(1'b0, 4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00});
        check("single_gap_ack", 32'(ack), 32'h0);
        drive(1'b0, 4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00});
        drive(1'b0, 4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00});
        check("single_cnt", 32'(wr_count), 32'h2);

        // Full contention: strict rotation, no idle cycles.
        drive(1'b1, 4'b0000, '0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 4'b1111, contention_data());
            check("contention_ack", 32'(ack), 32'(1 << (i % 4)));
            check("contention_q",   32'(q), 32'(8'h10 + (i % 4)));
        end

        // Fairness: requester 3 just won, so 0 is next, then 3.
        drive(1'b0, 4'b1001, contention_data());
        check("fair_after3_ack", 32'(ack), 32'h1);
        drive(1'b0, 4'b1001, contention_data());
        check("fair_after0_ack", 32'(ack), 32'h8);

        // Reset on the edge where requester 1 would win.
        drive(1'b1, 4'b0000, '0);
        drive(1'b0, 4'b0011, {8'h00, 8'h00, 8'h22, 8'h11});
        check("midrst_first_ack", 32'(ack), 32'h1);
        drive(1'b1, 4'b0011, {8'h00, 8'h00, 8'h22, 8'h11});
        check("midrst_ack", 32'(ack), 32'h0);
        check("midrst_q",   32'(q), 32'h0);
        drive(1'b0, 4'b0011, {8'h00, 8'h00, 8'h22, 8'h11});
        check("midrst_release_ack", 32'(ack), 32'h1);

        // Counter wrap at 2^CNTW.
        drive(1'b1, 4'b0000, '0);
        for (int i = 0; i < 17; i++) drive(1'b0, 4'b1111, $urandom);
        check("wrap_cnt",   32'(wr_count), 32'h1);
        check("wrap_valid", 32'(valid), 32'h1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)), $urandom);
        end

        drive(1'b0, 4'b0000, '0);
        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d predictions left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
